fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the core front end.
package cpu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order buffer of fetched {pc, instr} entries; flush wins over push.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    // pointers wrap at DEPTH so non-power-of-two depths work
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited word fetches and hands buffered
// instructions to decode; a redirect flushes the buffer and drops in-flight words.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] STEP    = 32'(INSTR_BYTES);

    logic [31:0]   fetch_pc, rsp_pc, target_pc;
    logic [CW-1:0] outstanding, discard, count;
    logic          req_fire, drop, push, pop;
    fetch_entry_t  rsp_entry, head;

    // buffered plus in-flight words never exceed the buffer, so a push always fits
    always_comb begin
        target_pc       = redirect_pc & ~32'h3;
        imem_req_valid  = rst_n && !redirect_valid &&
                          (({1'b0, outstanding} + {1'b0, count}) < CREDITS);
        imem_req_addr   = fetch_pc;
        req_fire        = imem_req_valid && imem_req_ready;
        drop            = redirect_valid || (discard != '0);
        push            = imem_rsp_valid && !drop;
        rsp_entry.pc    = rsp_pc;
        rsp_entry.instr = imem_rsp_data;
        out_valid       = (count != '0) && !redirect_valid;
        pop             = out_valid && out_ready;
        out_instr       = head.instr;
        out_pc          = head.pc;
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (rsp_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            // everything still in flight after this edge belongs to the old path
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc;
            outstanding <= outstanding - CW'(imem_rsp_valid);
            discard     <= outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + STEP;
            if (push) rsp_pc <= rsp_pc + STEP;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;
    int n_tests = 0, n_fail = 0, n_req = 0, n_out = 0, cyc = 0, lat = 1;
    int n0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // memory model: accepts at mid-cycle, answers in order 'lat' cycles later with addr^KEY
    task automatic tick();
        pend_t p;
        @(negedge clk);
        if (!rst_n) pend.delete();
        else if (imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            n_req++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rst_n && pend.size() != 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = p.addr ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic expect_pair(input logic [31:0] pc, input logic [31:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic expect_seq(input logic [31:0] pc, input int n);
        for (int i = 0; i < n; i++) expect_pair(pc + 32'(i * 4), (pc + 32'(i * 4)) ^ KEY);
    endtask

    task automatic drain();
        int k;
        imem_req_ready = 1'b0;
        out_ready      = 1'b1;
        k = 0;
        while ((pend.size() != 0 || imem_rsp_valid || out_valid) && k < 60) begin
            tick();
            k++;
        end
        check("drain_done", 32'(k < 60), 32'd1);
        exp_q.delete();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h, expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc", out_pc, mon_e.pc);
                check("out_instr", out_instr, mon_e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);

        // streaming: first request in the first cycle out of reset, output from cycle 2
        expect_seq(32'h0, 40);
        rst_n = 1'b1;
        #1;
        check("c0_req_valid", 32'(imem_req_valid), 32'd1);
        check("c0_req_addr", imem_req_addr, 32'h0);
        check("c0_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("c1_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("c2_out_valid", 32'(out_valid), 32'd1);
        check("c2_out_pc", out_pc, 32'h0);
        n0 = n_out;
        repeat (10) tick();
        check("throughput", 32'(n_out - n0), 32'd10);

        // decode stall: credits fill, head held, in-order resume
        out_ready = 1'b0;
        n0 = n_req;
        repeat (10) tick();
        check("stall_reqs", 32'(n_req - n0), 32'd2);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_head_pc", out_pc, 32'h28);
        out_ready = 1'b1;
        repeat (6) tick();
        drain();

        // three requests in flight, redirect to a misaligned target
        lat = 4;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #1;
        check("rd3_req_valid", 32'(imem_req_valid), 32'd0);
        check("rd3_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        expect_seq(32'h100, 16);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rd3_new_req_valid", 32'(imem_req_valid), 32'd1);
        check("rd3_new_req_addr", imem_req_addr, 32'h100);
        repeat (4) tick();
        check("rd3_stale_dropped", 32'(out_valid), 32'd0);
        tick();
        check("rd3_first_valid", 32'(out_valid), 32'd1);
        check("rd3_first_pc", out_pc, 32'h0000_0100);
        check("rd3_first_instr", out_instr, 32'hA5A5_0100);
        drain();

        // redirect coinciding with a response and a ready decode
        lat = 2;
        redirect_to(32'h40);
        expect_seq(32'h40, 16);
        imem_req_ready = 1'b1;
        repeat (8) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        check("rdr_out_valid", 32'(out_valid), 32'd0);
        check("rdr_req_valid", 32'(imem_req_valid), 32'd0);
        exp_q.delete();
        expect_seq(32'h200, 16);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rdr_fifo_empty", 32'(out_valid), 32'd0);
        check("rdr_req_addr", imem_req_addr, 32'h200);
        tick();
        check("rdr_stale_dropped", 32'(out_valid), 32'd0);
        tick();
        check("rdr_no_bypass", 32'(out_valid), 32'd0);
        tick();
        check("rdr_first_pc", out_pc, 32'h0000_0200);
        check("rdr_first_instr", out_instr, 32'hA5A5_0200);
        drain();

        // PC wraps modulo 2^32
        lat = 1;
        redirect_to(32'hFFFF_FFF8);
        expect_pair(32'hFFFF_FFF8, 32'h5A5A_FFF8);
        expect_pair(32'hFFFF_FFFC, 32'h5A5A_FFFC);
        expect_pair(32'h0000_0000, 32'hA5A5_0000);
        expect_pair(32'h0000_0004, 32'hA5A5_0004);
        expect_seq(32'h8, 12);
        n0 = n_out;
        imem_req_ready = 1'b1;
        repeat (6) tick();
        check("wrap_outputs", 32'(n_out - n0 >= 4), 32'd1);
        drain();

        // reset with two buffered and two outstanding
        lat = 3;
        redirect_to(32'h300);
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (5) tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_head", out_pc, 32'h300);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_pc", out_pc, 32'h0);
        check("mid_rst_out_instr", out_instr, 32'h0);
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("mid_rst_req_addr", imem_req_addr, 32'h0);
        expect_seq(32'h0, 16);
        out_ready = 1'b1;
        n0 = n_out;
        repeat (8) tick();
        check("post_rst_outputs", 32'(n_out - n0 >= 2), 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
